// File: rtl/frame_chunk_scheduler.sv
// Frame chunk scheduler: walks a host image request through the pixel controller
// one buffer-sized chunk at a time, with a per-chunk watchdog and abort.
module frame_chunk_scheduler #(
  parameter  int unsigned W_ADDR_SIZE_BITS = 16,
  parameter  int unsigned CHUNK_PIX        = 20,
  parameter  int unsigned WD_BITS          = 10,
  parameter  int unsigned TIMEOUT_CYCLES   = 1023,
  localparam int unsigned NUM_W            = 25,
  localparam int unsigned CNT_W            = 16
) (
  input  logic                        i_clk,
  input  logic                        i_n_rst,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [W_ADDR_SIZE_BITS-1:0] i_cfg_src_base,
  input  logic [W_ADDR_SIZE_BITS-1:0] i_cfg_dst_base,
  input  logic [NUM_W-1:0]            i_cfg_num_pixels,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic [CNT_W-1:0]            o_chunk_count,
  output logic                        o_pc_n_rst,
  output logic [W_ADDR_SIZE_BITS-1:0] o_pc_read_offset,
  output logic [W_ADDR_SIZE_BITS-1:0] o_pc_write_offset,
  output logic [NUM_W-1:0]            o_pc_num_pix,
  input  logic                        i_pc_end_of_operations
);

  localparam logic [NUM_W-1:0]   CHUNK_N = NUM_W'(CHUNK_PIX);
  localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_KICK,
    S_WAIT,
    S_ADVANCE,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t                        r_state;
  logic [W_ADDR_SIZE_BITS-1:0]   r_src;
  logic [W_ADDR_SIZE_BITS-1:0]   r_dst;
  logic [W_ADDR_SIZE_BITS-1:0]   r_idx;
  logic [NUM_W-1:0]              r_remaining;
  logic [WD_BITS-1:0]            r_wd;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_error;
  logic [CNT_W-1:0]              r_chunk_count;
  logic                          r_pc_n_rst;
  logic [W_ADDR_SIZE_BITS-1:0]   r_pc_read_offset;
  logic [W_ADDR_SIZE_BITS-1:0]   r_pc_write_offset;
  logic [NUM_W-1:0]              r_pc_num_pix;

  logic [NUM_W-1:0]              w_first_chunk;
  logic [NUM_W-1:0]              w_next_chunk;

  // Chunk size is the smaller of the buffer depth and what is left of the job
  assign w_first_chunk = (i_cfg_num_pixels > CHUNK_N) ? CHUNK_N : i_cfg_num_pixels;
  assign w_next_chunk  = (r_remaining > CHUNK_N) ? CHUNK_N : r_remaining;

  // Outputs are registered as the Moore value of the state being entered
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_state           <= S_IDLE;
      r_src             <= '0;
      r_dst             <= '0;
      r_idx             <= '0;
      r_remaining       <= '0;
      r_wd              <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_error           <= 1'b0;
      r_chunk_count     <= '0;
      r_pc_n_rst        <= 1'b0;
      r_pc_read_offset  <= '0;
      r_pc_write_offset <= '0;
      r_pc_num_pix      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (i_start) begin
            r_src         <= i_cfg_src_base;
            r_dst         <= i_cfg_dst_base;
            r_idx         <= '0;
            r_remaining   <= i_cfg_num_pixels;
            r_chunk_count <= '0;
            r_error       <= 1'b0;
            r_busy        <= 1'b1;
            if (i_cfg_num_pixels == '0) begin
              r_state    <= S_FINISH;
              r_done     <= 1'b1;
              r_pc_n_rst <= 1'b0;
            end else begin
              r_state           <= S_SETUP;
              r_pc_read_offset  <= i_cfg_src_base;
              r_pc_write_offset <= i_cfg_dst_base;
              r_pc_num_pix      <= w_first_chunk;
              r_pc_n_rst        <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          if (i_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_pc_n_rst <= 1'b0;
          end else begin
            r_state    <= S_KICK;
            r_pc_n_rst <= 1'b0;
          end
        end

        // Falling pc_n_rst with stable offsets makes the controller latch them
        S_KICK: begin
          if (i_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_pc_n_rst <= 1'b0;
          end else begin
            r_state    <= S_WAIT;
            r_pc_n_rst <= 1'b1;
            r_wd       <= '0;
          end
        end

        S_WAIT: begin
          if (i_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_pc_n_rst <= 1'b0;
          end else if (i_pc_end_of_operations) begin
            r_state       <= S_ADVANCE;
            r_pc_n_rst    <= 1'b0;
            r_idx         <= r_idx + W_ADDR_SIZE_BITS'(r_pc_num_pix);
            r_remaining   <= r_remaining - r_pc_num_pix;
            r_chunk_count <= r_chunk_count + CNT_W'(1);
          end else if (r_wd == WD_LAST) begin
            r_state    <= S_ERROR;
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
            r_pc_n_rst <= 1'b0;
          end else begin
            r_wd <= r_wd + WD_BITS'(1);
          end
        end

        // r_remaining already holds the post-chunk count here
        S_ADVANCE: begin
          if (i_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_pc_n_rst <= 1'b0;
          end else if (r_remaining == '0) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end else begin
            r_state           <= S_SETUP;
            r_pc_read_offset  <= r_src + r_idx;
            r_pc_write_offset <= r_dst + r_idx;
            r_pc_num_pix      <= w_next_chunk;
            r_pc_n_rst        <= 1'b1;
          end
        end

        S_FINISH: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_pc_n_rst <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_pc_n_rst <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_error           = r_error;
  assign o_chunk_count     = r_chunk_count;
  assign o_pc_n_rst        = r_pc_n_rst;
  assign o_pc_read_offset  = r_pc_read_offset;
  assign o_pc_write_offset = r_pc_write_offset;
  assign o_pc_num_pix      = r_pc_num_pix;

endmodule

// File: tb/tb_frame_chunk_scheduler.sv
// Bench for frame_chunk_scheduler: a job-level model queues the expected chunk,
// done and error events; a negedge monitor plays the pixel controller and checks them.
module tb_frame_chunk_scheduler;

  localparam int unsigned TIMEOUT = 1023;
  localparam int unsigned CHUNK   = 20;

  typedef enum int {EV_CHUNK = 0, EV_DONE = 1, EV_ERR = 2} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [15:0] rd;
    logic [15:0] wr;
    logic [24:0] num;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_src = '0;
  logic [15:0] cfg_dst = '0;
  logic [24:0] cfg_num = '0;
  logic        busy, done, error, pc_n_rst;
  logic [15:0] chunk_count, rd_off, wr_off;
  logic [24:0] num_pix;
  logic        eoo_resp = 1'b0;
  logic        eoo_force = 1'b0;
  logic        pc_eoo;

  assign pc_eoo = eoo_resp | eoo_force;

  frame_chunk_scheduler dut (
    .i_clk                  (clk),
    .i_n_rst                (n_rst),
    .i_start                (start),
    .i_abort                (abort),
    .i_cfg_src_base         (cfg_src),
    .i_cfg_dst_base         (cfg_dst),
    .i_cfg_num_pixels       (cfg_num),
    .o_busy                 (busy),
    .o_done                 (done),
    .o_error                (error),
    .o_chunk_count          (chunk_count),
    .o_pc_n_rst             (pc_n_rst),
    .o_pc_read_offset       (rd_off),
    .o_pc_write_offset      (wr_off),
    .o_pc_num_pix           (num_pix),
    .i_pc_end_of_operations (pc_eoo)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  int   resp_mode = 0;   // 0 random delay, 1 never respond, 2 fixed 30 cycles
  int   rise_cnt = 0;
  int   countdown = -1;
  int   cyc = 0;
  int   wait_cyc = 0;
  logic prev_n_rst = 1'b0;
  logic prev_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: job -> list of chunks, then done (or error after stop_after chunks)
  function automatic void push_job(input logic [15:0] src, input logic [15:0] dst,
                                   input int num, input int stop_after);
    int   rem = num;
    int   idx = 0;
    int   k = 0;
    exp_t e;
    while (rem > 0) begin
      e.kind = EV_CHUNK;
      e.rd   = 16'(32'(src) + idx);
      e.wr   = 16'(32'(dst) + idx);
      e.num  = 25'((rem > int'(CHUNK)) ? int'(CHUNK) : rem);
      e.cnt  = 16'(k);
      sb_q.push_back(e);
      idx += int'(e.num);
      rem -= int'(e.num);
      k++;
      if (k == stop_after) begin
        e.kind = EV_ERR;
        e.cnt  = 16'(k - 1);
        sb_q.push_back(e);
        return;
      end
    end
    e.kind = EV_DONE;
    e.rd   = '0;
    e.wr   = '0;
    e.num  = '0;
    e.cnt  = 16'(k);
    sb_q.push_back(e);
  endfunction

  // Monitor + pixel-controller responder; rises of pc_n_rst alternate SETUP / WAIT
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!busy) rise_cnt = 0;
    else if (pc_n_rst && !prev_n_rst) begin
      rise_cnt++;
      if (rise_cnt % 2 == 1) begin
        if (sb_q.size() == 0) chk("unexpected_chunk", 32'(rd_off), 32'hFFFF_FFFF);
        else begin
          e = sb_q.pop_front();
          chk("chunk_event_kind", 32'(EV_CHUNK), 32'(e.kind));
          chk("chunk_read_offset", 32'(rd_off), 32'(e.rd));
          chk("chunk_write_offset", 32'(wr_off), 32'(e.wr));
          chk("chunk_num_pix", 32'(num_pix), 32'(e.num));
          chk("chunk_count_at_setup", 32'(chunk_count), 32'(e.cnt));
        end
      end else begin
        wait_cyc = cyc;
        case (resp_mode)
          0:       countdown = int'($urandom_range(0, 40));
          1:       countdown = -1;
          default: countdown = 30;
        endcase
      end
    end
    prev_n_rst = pc_n_rst;
    if (countdown == 0) begin
      eoo_resp  = 1'b1;
      countdown = -1;
    end else begin
      eoo_resp = 1'b0;
      if (countdown > 0) countdown--;
    end
    if (done) begin
      if (sb_q.size() == 0) chk("unexpected_done", 32'(done), 32'(0));
      else begin
        e = sb_q.pop_front();
        chk("done_event_kind", 32'(EV_DONE), 32'(e.kind));
        chk("done_chunk_count", 32'(chunk_count), 32'(e.cnt));
        chk("done_busy", 32'(busy), 32'(1));
        chk("done_pc_n_rst", 32'(pc_n_rst), 32'(0));
      end
    end
    if (error && !prev_err) begin
      if (sb_q.size() == 0) chk("unexpected_error", 32'(error), 32'(0));
      else begin
        e = sb_q.pop_front();
        chk("error_event_kind", 32'(EV_ERR), 32'(e.kind));
        chk("watchdog_wait_cycles", 32'(cyc - wait_cyc), 32'(TIMEOUT));
        chk("error_chunk_count", 32'(chunk_count), 32'(e.cnt));
      end
    end
    prev_err = error;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_error"}, 32'(error), 32'(0));
    chk({tag, "_chunk_count"}, 32'(chunk_count), 32'(0));
    chk({tag, "_pc_n_rst"}, 32'(pc_n_rst), 32'(0));
    chk({tag, "_read_offset"}, 32'(rd_off), 32'(0));
    chk({tag, "_write_offset"}, 32'(wr_off), 32'(0));
    chk({tag, "_num_pix"}, 32'(num_pix), 32'(0));
  endtask

  task automatic pulse_start(input logic [15:0] src, input logic [15:0] dst, input int num);
    cfg_src = src;
    cfg_dst = dst;
    cfg_num = 25'(num);
    start   = 1'b1;
    step();
    start   = 1'b0;
    cfg_src = $urandom();
    cfg_dst = $urandom();
    cfg_num = 25'($urandom_range(0, 500));
  endtask

  task automatic wait_idle(input string name, input int bound);
    logic ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (sb_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(name, 32'(ok), 32'(1));
  endtask

  task automatic wait_rise(input string name, input int target);
    logic ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (rise_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(name, 32'(ok), 32'(1));
  endtask

  task automatic run_job(input logic [15:0] src, input logic [15:0] dst, input int num);
    push_job(src, dst, num, -1);
    pulse_start(src, dst, num);
    chk("busy_after_start", 32'(busy), 32'(1));
    chk("error_cleared_on_start", 32'(error), 32'(0));
    if (num == 0) chk("zero_job_done_next_cycle", 32'(done), 32'(1));
    wait_idle("job_completes", 5000);
    chk("final_chunk_count", 32'(chunk_count), 32'((num + int'(CHUNK) - 1) / int'(CHUNK)));
    chk("done_low_after_job", 32'(done), 32'(0));
    chk("pc_n_rst_parked", 32'(pc_n_rst), 32'(0));
  endtask

  initial begin
    int num;
    repeat (3) step();
    check_reset_vals("reset");
    n_rst = 1'b1;
    step();

    // Three-chunk job with 30-cycle controller latency
    resp_mode = 2;
    run_job(16'h0100, 16'h8000, 45);

    // Zero-pixel job
    run_job(16'h1234, 16'h5678, 0);

    // 16-bit address wrap between chunks
    run_job(16'hFFF0, 16'hFFFC, 40);

    // Randomized jobs around the chunk-size boundaries
    resp_mode = 0;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: num = 1;
        1: num = 19;
        2: num = 20;
        3: num = 21;
        4: num = 41;
        5: num = 60;
        6: num = int'($urandom_range(2, 100));
        default: num = int'($urandom_range(100, 200));
      endcase
      run_job(16'($urandom()), 16'($urandom()), num);
    end

    // Watchdog: controller never answers
    resp_mode = 1;
    push_job(16'h0200, 16'h0300, 50, 1);
    pulse_start(16'h0200, 16'h0300, 50);
    for (int i = 0; i < 1500 && !error; i++) step();
    chk("watchdog_error_set", 32'(error), 32'(1));
    chk("watchdog_busy_low", 32'(busy), 32'(0));
    chk("watchdog_pc_n_rst_low", 32'(pc_n_rst), 32'(0));
    chk("watchdog_queue_drained", 32'(sb_q.size()), 32'(0));
    resp_mode = 2;
    run_job(16'h0400, 16'h0500, 25);
    chk("error_stays_clear", 32'(error), 32'(0));

    // Abort in the 5th WAIT cycle of chunk 2; a start mid-job is ignored
    push_job(16'h0A00, 16'h0B00, 60, -1);
    pulse_start(16'h0A00, 16'h0B00, 60);
    wait_rise("reach_wait_chunk1", 2);
    pulse_start(16'h7777, 16'h6666, 3);
    wait_rise("reach_wait_chunk2", 4);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_pc_n_rst", 32'(pc_n_rst), 32'(0));
    chk("abort_chunk_count", 32'(chunk_count), 32'(1));
    chk("abort_events_left", 32'(sb_q.size()), 32'(2));
    sb_q.delete();
    repeat (40) step();
    chk("abort_no_late_done", 32'(busy | done), 32'(0));

    // Synchronous reset in the middle of WAIT
    push_job(16'h0100, 16'h8000, 45, -1);
    pulse_start(16'h0100, 16'h8000, 45);
    wait_rise("reach_wait_for_reset", 2);
    repeat (3) step();
    n_rst = 1'b0;
    step();
    check_reset_vals("midjob_reset");
    n_rst = 1'b1;
    chk("reset_events_left", 32'(sb_q.size()), 32'(3));
    sb_q.delete();
    eoo_force = 1'b1;
    repeat (3) step();
    eoo_force = 1'b0;
    chk("eoo_ignored_busy", 32'(busy), 32'(0));
    chk("eoo_ignored_pc_n_rst", 32'(pc_n_rst), 32'(0));
    chk("eoo_ignored_chunk_count", 32'(chunk_count), 32'(0));
    repeat (40) step();
    chk("reset_no_late_done", 32'(busy | done), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
